// File: rtl/pc_redirect_unit_if.sv
// Bus between the pipeline (ID/MEM/IF control) and the PC redirect unit.
// The master drives the request inputs; the slave returns the redirect and its counter.
interface pc_redirect_unit_if #(
  parameter int unsigned AW   = 32,
  parameter int unsigned CNTW = 16
);
  logic            id_jump;
  logic [AW-1:0]   id_jump_target;
  logic            mem_branch;
  logic            mem_zero;
  logic [AW-1:0]   mem_branch_target;
  logic            if_stall;
  logic            pcload;
  logic            jump;
  logic [AW-1:0]   redirect_pc;
  logic [CNTW-1:0] redirect_count;

  modport master (
    output id_jump, id_jump_target, mem_branch, mem_zero, mem_branch_target, if_stall,
    input  pcload, jump, redirect_pc, redirect_count
  );

  modport slave (
    input  id_jump, id_jump_target, mem_branch, mem_zero, mem_branch_target, if_stall,
    output pcload, jump, redirect_pc, redirect_count
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Resolves MEM branches and ID jumps into a pcload/jump/target redirect, holds it
// across IF stalls, masks the post-branch shadow and counts accepted redirects.
module pc_redirect_unit #(
  parameter int unsigned AW         = 32,
  parameter int unsigned CNTW       = 16,
  parameter int unsigned SHADOW_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_redirect_unit_if.slave  bus
);

  localparam int unsigned SHW = (SHADOW_CYC > 0) ? $clog2(SHADOW_CYC + 1) : 1;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic            held_jump_q, held_jump_d;
  logic [AW-1:0]   held_pc_q, held_pc_d;
  logic [SHW-1:0]  shadow_q, shadow_d;
  logic [CNTW-1:0] count_q, count_d;

  logic          br_req, jp_req, accept;
  logic          sel_pcload, sel_jump;
  logic [AW-1:0] sel_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      held_jump_q <= 1'b0;
      held_pc_q   <= '0;
      shadow_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      held_jump_q <= held_jump_d;
      held_pc_q   <= held_pc_d;
      shadow_q    <= shadow_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    held_jump_d = held_jump_q;
    held_pc_d   = held_pc_q;
    shadow_d    = (shadow_q != '0) ? shadow_q - SHW'(1) : shadow_q;
    count_d     = count_q;
    sel_pcload  = 1'b0;
    sel_jump    = 1'b0;
    sel_pc      = '0;

    br_req = bus.mem_branch & bus.mem_zero & (shadow_q == '0);
    jp_req = bus.id_jump;

    case (state_q)
      IDLE: begin
        // MEM branch is the older instruction, so it wins a tie with an ID jump
        if (br_req) begin
          sel_pcload = 1'b1;
          sel_pc     = bus.mem_branch_target;
        end else if (jp_req) begin
          sel_pcload = 1'b1;
          sel_jump   = 1'b1;
          sel_pc     = bus.id_jump_target;
        end
        if (sel_pcload && bus.if_stall) begin
          state_d     = HOLD;
          held_jump_d = sel_jump;
          held_pc_d   = sel_pc;
        end
      end
      HOLD: begin
        // A held jump is superseded at once by a taken branch; a held branch is final
        sel_pcload = 1'b1;
        if (held_jump_q && br_req) begin
          sel_jump = 1'b0;
          sel_pc   = bus.mem_branch_target;
        end else begin
          sel_jump = held_jump_q;
          sel_pc   = held_pc_q;
        end
        held_jump_d = sel_jump;
        held_pc_d   = sel_pc;
        if (!bus.if_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    accept = sel_pcload & ~bus.if_stall;
    if (accept) begin
      if (!sel_jump) shadow_d = SHW'(SHADOW_CYC);
      if (count_q != '1) count_d = count_q + CNTW'(1);
    end
  end

  // Outputs are forced inactive for as long as reset is asserted
  assign bus.pcload         = rst_n & sel_pcload;
  assign bus.jump           = rst_n & sel_jump;
  assign bus.redirect_pc    = rst_n ? sel_pc : '0;
  assign bus.redirect_count = count_q;

endmodule
